// File: rtl/countdown_display_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : countdown_pkg
// Description : Shared types, seven-segment glyphs and BCD helpers for the
//               countdown_display_mux timer.
// Revision    : 1.0 - initial release
// ============================================================================
package countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Active-low glyphs, bit6 = segment a ... bit0 = segment g
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] nib);
        return (nib > 4'd9) ? 4'd9 : nib;
    endfunction

    // Up to eight BCD digits of a binary value, nibble 0 least significant
    function automatic logic [31:0] to_bcd(input int unsigned value);
        logic [31:0] bcd;
        int unsigned v;
        bcd = '0;
        v   = value;
        for (int i = 0; i < 8; i++) begin
            bcd[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return bcd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/countdown_display_mux_bcd_to_7seg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_7seg
// Description : Combinational BCD nibble to active-low seven-segment glyph;
//               codes above 9 blank the digit.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_7seg
    import countdown_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/countdown_display_mux.sv
`default_nettype none
// ============================================================================
// Module      : countdown_display_mux
// Description : N-digit BCD countdown timer with start/pause/load control and
//               a multiplexed active-low seven-segment driver.
//               Optional: COUNTDOWN_LEADING_ZERO_BLANK_EN blanks leading zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_display_mux
    import countdown_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TICK_HZ     = 1,
    parameter int DIGITS      = 2,
    parameter int START_VALUE = 30,
    parameter int REFRESH_DIV = 9334
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic                  running,
    output logic                  done,
    output logic                  led,
    output logic [6:0]            segmentos,
    output logic [DIGITS-1:0]     displays
);

    localparam int c_TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int c_PRE_W    = $clog2(c_TICK_DIV);
    localparam int c_SCAN_W   = $clog2(REFRESH_DIV);
    localparam int c_IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int c_CNT_W    = 4 * DIGITS;

    localparam logic [31:0]          c_START_BCD32 = to_bcd(START_VALUE);
    localparam logic [c_CNT_W-1:0]   c_START_BCD   = c_START_BCD32[c_CNT_W-1:0];
    localparam logic [c_PRE_W-1:0]   c_PRE_LAST    = c_PRE_W'(c_TICK_DIV - 1);
    localparam logic [c_SCAN_W-1:0]  c_SCAN_LAST   = c_SCAN_W'(REFRESH_DIV - 1);
    localparam logic [c_IDX_W-1:0]   c_IDX_LAST    = c_IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0]    c_DISP_ONE    = DIGITS'(1);

    state_t                r_state, w_state_next;
    logic [c_CNT_W-1:0]    r_count, w_count_next, w_count_dec;
    logic [c_CNT_W-1:0]    r_reload, w_reload_next, w_load_clamped;
    logic [c_PRE_W-1:0]    r_prescale, w_prescale_next;
    logic                  w_done_next, w_tick;
    logic                  r_done, r_running, r_led;
    logic [c_SCAN_W-1:0]   r_scan_cnt;
    logic [c_IDX_W-1:0]    r_scan_idx;
    logic [3:0]            w_nibble, w_nibble_shown;
    logic [6:0]            w_glyph, r_seg;
    logic [DIGITS-1:0]     r_displays;

    for (genvar g = 0; g < DIGITS; g++) begin : g_clamp
        assign w_load_clamped[4*g +: 4] = bcd_clamp(load_value[4*g +: 4]);
    end

    assign w_tick = (r_prescale == c_PRE_LAST);

    // Ripple-borrow BCD decrement; saturates at zero
    always_comb begin : p_bcd_dec
        logic borrow;
        borrow      = 1'b1;
        w_count_dec = r_count;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (r_count[4*i +: 4] == 4'd0) begin
                    w_count_dec[4*i +: 4] = 4'd9;
                end else begin
                    w_count_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
        if (r_count == '0) begin
            w_count_dec = '0;
        end
    end

    always_comb begin : p_next
        w_state_next    = r_state;
        w_count_next    = r_count;
        w_reload_next   = r_reload;
        w_prescale_next = r_prescale;
        w_done_next     = 1'b0;
        if (load) begin
            w_count_next    = w_load_clamped;
            w_reload_next   = w_load_clamped;
            w_prescale_next = '0;
            w_state_next    = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        w_count_next    = (r_state == ST_DONE) ? r_reload : r_count;
                        w_prescale_next = '0;
                        if (w_count_next == '0) begin
                            w_state_next = ST_DONE;
                            w_done_next  = 1'b1;
                        end else if (pause) begin
                            w_state_next = ST_PAUSED;
                        end else begin
                            w_state_next = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    // The current cycle's prescaler step completes even when pause arrives
                    if (w_tick) begin
                        w_prescale_next = '0;
                        w_count_next    = w_count_dec;
                    end else begin
                        w_prescale_next = r_prescale + c_PRE_W'(1);
                    end
                    if (w_tick && (w_count_dec == '0)) begin
                        w_state_next = ST_DONE;
                        w_done_next  = 1'b1;
                    end else if (pause) begin
                        w_state_next = ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (!pause) begin
                        w_state_next = ST_RUN;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_count    <= c_START_BCD;
            r_reload   <= c_START_BCD;
            r_prescale <= '0;
            r_done     <= 1'b0;
            r_running  <= 1'b0;
            r_led      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            r_reload   <= w_reload_next;
            r_prescale <= w_prescale_next;
            r_done     <= w_done_next;
            r_running  <= (w_state_next == ST_RUN);
            r_led      <= (w_state_next == ST_DONE);
        end
    end

    always_comb begin : p_digit_mux
        w_nibble = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_scan_idx == c_IDX_W'(i)) begin
                w_nibble = r_count[4*i +: 4];
            end
        end
    end

`ifdef COUNTDOWN_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] w_upper_zero;
    for (genvar g = 0; g < DIGITS; g++) begin : g_upper_zero
        assign w_upper_zero[g] = (r_count[c_CNT_W-1:4*g] == '0);
    end
    // Code 4'hF decodes to a blank glyph
    assign w_nibble_shown = ((r_scan_idx != '0) && w_upper_zero[r_scan_idx]) ? 4'hF : w_nibble;
`else
    assign w_nibble_shown = w_nibble;
`endif

    bcd_to_7seg u_bcd_to_7seg (
        .i_bcd (w_nibble_shown),
        .o_seg (w_glyph)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_scan_cnt <= '0;
            r_scan_idx <= '0;
            r_seg      <= SEG_BLANK;
            r_displays <= '1;
        end else begin
            if (r_scan_cnt == c_SCAN_LAST) begin
                r_scan_cnt <= '0;
                r_scan_idx <= (r_scan_idx == c_IDX_LAST) ? '0 : r_scan_idx + c_IDX_W'(1);
            end else begin
                r_scan_cnt <= r_scan_cnt + c_SCAN_W'(1);
            end
            r_seg      <= w_glyph;
            r_displays <= ~(c_DISP_ONE << r_scan_idx);
        end
    end

    assign running   = r_running;
    assign done      = r_done;
    assign led       = r_led;
    assign segmentos = r_seg;
    assign displays  = r_displays;

endmodule
`default_nettype wire

// File: tb/tb_countdown_display_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_countdown_display_mux
// Description : Self-checking bench for countdown_display_mux against an
//               integer-level reference model of the timer and scan.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_display_mux;

    localparam int P_CLK_HZ  = 10;
    localparam int P_TICK_HZ = 1;
    localparam int P_DIGITS  = 3;
    localparam int P_START   = 30;
    localparam int P_RDIV    = 4;
    localparam int DIV       = P_CLK_HZ / P_TICK_HZ;
    localparam int OW        = 10 + P_DIGITS;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0, pause = 1'b0, load = 1'b0;
    logic [4*P_DIGITS-1:0] load_value = '0;
    logic running, done, led;
    logic [6:0] segmentos;
    logic [P_DIGITS-1:0] displays;

    int checks = 0;
    int errors = 0;

    int m_state, m_count, m_reload, m_phase, m_scan;
    logic m_done;
    logic [6:0] m_seg;
    logic [P_DIGITS-1:0] m_disp;

    logic [6:0] glyph [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    countdown_display_mux #(
        .CLK_HZ      (P_CLK_HZ),
        .TICK_HZ     (P_TICK_HZ),
        .DIGITS      (P_DIGITS),
        .START_VALUE (P_START),
        .REFRESH_DIV (P_RDIV)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .pause      (pause),
        .load       (load),
        .load_value (load_value),
        .running    (running),
        .done       (done),
        .led        (led),
        .segmentos  (segmentos),
        .displays   (displays)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] expect_glyph(input int pos, input int value);
`ifdef COUNTDOWN_LEADING_ZERO_BLANK_EN
        if (pos > 0 && value < pow10(pos)) return 7'h7F;
`endif
        return glyph[(value / pow10(pos)) % 10];
    endfunction

    function automatic int bcd_value(input logic [4*P_DIGITS-1:0] bcd);
        int v, d;
        v = 0;
        for (int i = P_DIGITS - 1; i >= 0; i--) begin
            d = int'(bcd[4*i +: 4]);
            if (d > 9) d = 9;
            v = v * 10 + d;
        end
        return v;
    endfunction

    function automatic void model_reset();
        m_state  = M_IDLE;
        m_count  = P_START;
        m_reload = P_START;
        m_phase  = 0;
        m_scan   = 0;
        m_done   = 1'b0;
        m_seg    = 7'h7F;
        m_disp   = '1;
    endfunction

    // One rising edge of the reference timer
    function automatic void model_edge(input logic s, input logic l,
                                       input logic [4*P_DIGITS-1:0] lv, input logic p);
        int pos;
        logic [P_DIGITS-1:0] one;
        one    = 1;
        pos    = (m_scan / P_RDIV) % P_DIGITS;
        m_disp = ~(one << pos);
        m_seg  = expect_glyph(pos, m_count);
        m_scan = m_scan + 1;
        m_done = 1'b0;
        if (l) begin
            m_count  = bcd_value(lv);
            m_reload = m_count;
            m_phase  = 0;
            m_state  = M_IDLE;
        end else if (m_state == M_IDLE || m_state == M_DONE) begin
            if (s) begin
                if (m_state == M_DONE) m_count = m_reload;
                m_phase = 0;
                if (m_count == 0) begin
                    m_state = M_DONE;
                    m_done  = 1'b1;
                end else begin
                    m_state = p ? M_PAUSED : M_RUN;
                end
            end
        end else if (m_state == M_RUN) begin
            m_phase = m_phase + 1;
            if (m_phase == DIV) begin
                m_phase = 0;
                m_count = m_count - 1;
                if (m_count == 0) begin
                    m_state = M_DONE;
                    m_done  = 1'b1;
                end
            end
            if (m_state == M_RUN && p) m_state = M_PAUSED;
        end else begin
            if (!p) m_state = M_RUN;
        end
    endfunction

    function automatic logic [OW-1:0] dut_outs();
        return {running, done, led, segmentos, displays};
    endfunction

    function automatic logic [OW-1:0] exp_outs();
        return {(m_state == M_RUN), m_done, (m_state == M_DONE), m_seg, m_disp};
    endfunction

    task automatic cycle(input logic s, input logic l, input logic [4*P_DIGITS-1:0] lv,
                         input logic p);
        start = s;
        load = l;
        load_value = lv;
        pause = p;
        @(posedge clock);
        model_edge(s, l, lv, p);
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        checks++;
        if ({running, done, led, segmentos, displays} !== {3'b000, 7'h7F, 3'b111}) begin
            errors++;
            $display("FAIL reset_values got=%h exp=%h", {running, done, led, segmentos, displays},
                     {3'b000, 7'h7F, 3'b111});
        end
        reset_n = 1'b1;
        cycle(0, 0, '0, 0);
        checks++;
        if (displays !== 3'b110 || dut_outs() !== exp_outs()) begin
            errors++;
            $display("FAIL first_scan got=%h exp=%h", dut_outs(), exp_outs());
        end
    endtask

    task automatic test_run_to_zero();
        int pulses;
        pulses = 0;
        cycle(1, 0, '0, 0);
        checks++;
        if (running !== 1'b1 || dut_outs() !== exp_outs()) begin
            errors++;
            $display("FAIL start_run got=%h exp=%h", dut_outs(), exp_outs());
        end
        for (int k = 1; k <= 305; k++) begin
            cycle(0, 0, '0, 0);
            if (done === 1'b1) pulses++;
            checks++;
            if (dut_outs() !== exp_outs()) begin
                errors++;
                $display("FAIL run_to_zero cyc=%0d got=%h exp=%h", k, dut_outs(), exp_outs());
            end
            if (k == 300) begin
                checks++;
                if (done !== 1'b1) begin
                    errors++;
                    $display("FAIL done_at_300 got=%b exp=1", done);
                end
            end
        end
        checks++;
        if (pulses != 1 || led !== 1'b1 || running !== 1'b0) begin
            errors++;
            $display("FAIL done_final pulses=%0d led=%b running=%b exp 1/1/0", pulses, led, running);
        end
    endtask

    task automatic test_borrow();
        logic seen;
        logic [6:0] want;
`ifdef COUNTDOWN_LEADING_ZERO_BLANK_EN
        want = 7'h7F;
`else
        want = 7'b0000001;
`endif
        seen = 1'b0;
        cycle(0, 1, 12'h100, 0);
        cycle(1, 0, '0, 0);
        for (int k = 1; k <= 22; k++) begin
            cycle(0, 0, '0, 0);
            checks++;
            if (dut_outs() !== exp_outs()) begin
                errors++;
                $display("FAIL borrow cyc=%0d got=%h exp=%h", k, dut_outs(), exp_outs());
            end
            if (k > 10 && displays === 3'b011 && !seen) begin
                seen = 1'b1;
                checks++;
                if (segmentos !== want) begin
                    errors++;
                    $display("FAIL borrow_digit2 got=%b exp=%b", segmentos, want);
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL borrow_scan digit2 never selected got=0 exp=1");
        end
    endtask

    task automatic test_pause();
        cycle(0, 1, 12'h001, 0);
        cycle(1, 0, '0, 0);
        for (int k = 1; k <= 53; k++) begin
            cycle(0, 0, '0, (k >= 4));
            checks++;
            if (dut_outs() !== exp_outs()) begin
                errors++;
                $display("FAIL pause cyc=%0d got=%h exp=%h", k, dut_outs(), exp_outs());
            end
        end
        checks++;
        if (running !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL pause_hold running=%b done=%b exp 0/0", running, done);
        end
        cycle(0, 0, '0, 0);
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL pause_release running=%b exp=1", running);
        end
        for (int k = 1; k <= 8; k++) begin
            cycle(0, 0, '0, 0);
            checks++;
            if (done !== (k == 6) || dut_outs() !== exp_outs()) begin
                errors++;
                $display("FAIL resume_tick k=%0d got=%h exp=%h", k, dut_outs(), exp_outs());
            end
        end
    endtask

    task automatic test_invalid_load();
        cycle(0, 1, 12'h0A7, 0);
        cycle(1, 0, '0, 1);
        checks++;
        if (running !== 1'b0 || led !== 1'b0) begin
            errors++;
            $display("FAIL start_paused running=%b led=%b exp 0/0", running, led);
        end
        for (int k = 1; k <= 20; k++) begin
            cycle(0, 0, '0, (k <= 14));
            checks++;
            if (dut_outs() !== exp_outs()) begin
                errors++;
                $display("FAIL invalid_load cyc=%0d got=%h exp=%h", k, dut_outs(), exp_outs());
            end
        end
    endtask

    task automatic test_load_start_run();
        cycle(1, 1, 12'h042, 0);
        checks++;
        if (running !== 1'b0 || done !== 1'b0 || dut_outs() !== exp_outs()) begin
            errors++;
            $display("FAIL load_over_start got=%h exp=%h", dut_outs(), exp_outs());
        end
        cycle(0, 1, 12'h000, 0);
        cycle(1, 0, '0, 0);
        checks++;
        if (done !== 1'b1 || led !== 1'b1) begin
            errors++;
            $display("FAIL zero_start done=%b led=%b exp 1/1", done, led);
        end
        cycle(0, 0, '0, 0);
        checks++;
        if (done !== 1'b0 || led !== 1'b1 || dut_outs() !== exp_outs()) begin
            errors++;
            $display("FAIL zero_start_after got=%h exp=%h", dut_outs(), exp_outs());
        end
    endtask

    task automatic test_random();
        logic p, s, l;
        logic [4*P_DIGITS-1:0] lv;
        p = 1'b0;
        for (int k = 0; k < 2500; k++) begin
            s = ($urandom_range(0, 19) == 0);
            l = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 24) == 0) p = ~p;
            lv[3:0]  = 4'($urandom_range(0, 15));
            lv[7:4]  = 4'($urandom_range(0, 15));
            lv[11:8] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            if (bcd_value(lv) == 0) lv[3:0] = 4'd3;
            cycle(s, l, lv, p);
            checks++;
            if (dut_outs() !== exp_outs()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", k, dut_outs(), exp_outs());
            end
        end
    endtask

    task automatic test_scan_reset();
        int pulses;
        logic [P_DIGITS-1:0] one;
        one = 1;
        pulses = 0;
        cycle(0, 1, 12'h001, 0);
        cycle(1, 0, '0, 0);
        repeat (8) cycle(0, 0, '0, 0);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({running, done, led, segmentos, displays} !== {3'b000, 7'h7F, 3'b111}) begin
            errors++;
            $display("FAIL midscan_reset got=%h exp=%h", {running, done, led, segmentos, displays},
                     {3'b000, 7'h7F, 3'b111});
        end
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            cycle(0, 0, '0, 0);
            if (done === 1'b1) pulses++;
            checks++;
            if (displays !== ~(one << (((k - 1) / P_RDIV) % P_DIGITS)) || dut_outs() !== exp_outs()) begin
                errors++;
                $display("FAIL scan_after_reset k=%0d got=%h exp=%h", k, dut_outs(), exp_outs());
            end
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL reset_no_done pulses=%0d exp=0", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_run_to_zero();
        test_borrow();
        test_pause();
        test_invalid_load();
        test_load_start_run();
        test_random();
        test_scan_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
